// File: rtl/gray_count_checker.sv
// Receive-side checker for a free-running Gray/binary counter stream.
// Optional Gray decoder: define GRAY_DECODE_EN, otherwise in_count is binary.
module gray_count_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_count,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 bin_valid,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int RW = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  logic [1:0]       state;
  logic [RW-1:0]    run;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] dec;
  logic             good;
  logic             run_done;

`ifdef GRAY_DECODE_EN
  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    dec = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = ^(in_count >> i);
    end
  end
`else
  assign dec = in_count;
`endif

  assign good     = (dec == ref_q + WIDTH'(1));
  assign run_done = ((run + RW'(1)) == RW'(LOCK_COUNT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= HUNT;
      run       <= '0;
      ref_q     <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else if (!in_valid) begin
      bin_valid <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      ref_q     <= dec;
      bin_out   <= dec;
      bin_valid <= 1'b1;
      err_pulse <= 1'b0;
      unique case (1'b1)
        (state == HUNT): begin
          run   <= '0;
          state <= ACQUIRE;
        end
        (state == ACQUIRE): begin
          if (good) begin
            run <= run + RW'(1);
            if (run_done) begin
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end else begin
            run <= '0;
          end
        end
        (state == LOCKED): begin
          if (!good) begin
            err_pulse <= 1'b1;
            if (err_count != '1) begin
              err_count <= err_count + ERR_CNT_W'(1);
            end
            run    <= '0;
            locked <= 1'b0;
            state  <= ACQUIRE;
          end
        end
        default: begin
          run    <= '0;
          locked <= 1'b0;
          state  <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_count_checker.sv
// Self-checking bench for gray_count_checker: behavioural model + directed
// vectors; works in both the GRAY_DECODE_EN and plain binary builds.
module tb_gray_count_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_count = 8'h00;

  logic [7:0] bin_out;
  logic       bin_valid;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;

  logic [7:0] bin_out2;
  logic       bin_valid2;
  logic       locked2;
  logic       err_pulse2;
  logic [1:0] err_count2;

  int n_chk = 0;
  int n_fail = 0;

`ifdef GRAY_DECODE_EN
  localparam bit GRAY = 1'b1;
`else
  localparam bit GRAY = 1'b0;
`endif

  always #5 clk = ~clk;

  gray_count_checker u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
  );

  gray_count_checker #(.ERR_CNT_W(2)) u_sat (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .bin_out   (bin_out2),
    .bin_valid (bin_valid2),
    .locked    (locked2),
    .err_pulse (err_pulse2),
    .err_count (err_count2)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc(input int b);
    logic [7:0] v;
    v = 8'(b);
    return GRAY ? (v ^ (v >> 1)) : v;
  endfunction

  function automatic logic [7:0] pick(input logic [7:0] g,
                                      input logic [7:0] b);
    return GRAY ? g : b;
  endfunction

  function automatic int model_dec(input logic [7:0] raw);
    int  b;
    bit  acc;
    if (!GRAY) return int'(raw);
    b = 0;
    acc = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      acc = acc ^ raw[i];
      if (acc) b = b + (1 << i);
    end
    return b;
  endfunction

  // Behavioural model: expected outputs after each clock edge
  int m_bin = 0, m_bv = 0, m_lk = 0, m_ep = 0, m_errs = 0;
  int m_ref = 0, m_run = 0, m_have = 0;

  initial forever begin
    int v;
    @(posedge clk or posedge reset);
    if (reset) begin
      m_bin = 0; m_bv = 0; m_lk = 0; m_ep = 0; m_errs = 0;
      m_ref = 0; m_run = 0; m_have = 0;
    end else if (in_valid) begin
      v = model_dec(in_count);
      m_bv = 1;
      m_bin = v;
      m_ep = 0;
      if (m_have == 0) begin
        m_have = 1;
        m_run = 0;
      end else if (v == (m_ref + 1) % 256) begin
        if (m_run < 4) m_run = m_run + 1;
        if (m_run >= 4) m_lk = 1;
      end else begin
        if (m_lk != 0) begin
          m_ep = 1;
          m_errs = m_errs + 1;
        end
        m_lk = 0;
        m_run = 0;
      end
      m_ref = v;
    end else begin
      m_bv = 0;
      m_ep = 0;
    end
  end

  // Continuous compare against the model
  initial begin
    repeat (3) @(negedge clk);
    forever begin
      @(negedge clk);
      chk("m_bin_valid", bin_valid, m_bv);
      if (m_bv != 0) chk("m_bin_out", bin_out, m_bin);
      chk("m_locked", locked, m_lk);
      chk("m_err_pulse", err_pulse, m_ep);
      chk("m_err_count", err_count, (m_errs > 255) ? 255 : m_errs);
      chk("m_err_count_sat", err_count2, (m_errs > 3) ? 3 : m_errs);
      chk("m_sat_locked", locked2, m_lk);
    end
  end

  task automatic send(input logic [7:0] raw);
    @(negedge clk);
    in_valid = 1'b1;
    in_count = raw;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("gap_bin_valid", bin_valid, 0);
      chk("gap_locked", locked, 1);
    end
  endtask

  int cur;

  initial begin
    @(posedge clk);
    #2;
    chk("rst_bin_out", bin_out, 0);
    chk("rst_bin_valid", bin_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // Lock acquisition
    send(pick(8'h00, 8'h00)); chk("lk_bin0", bin_out, 0);
    chk("lk_locked0", locked, 0);
    send(pick(8'h01, 8'h01)); chk("lk_bin1", bin_out, 1);
    send(pick(8'h03, 8'h02)); chk("lk_bin2", bin_out, 2);
    send(pick(8'h02, 8'h03)); chk("lk_bin3", bin_out, 3);
    chk("lk_locked3", locked, 0);
    send(pick(8'h06, 8'h04)); chk("lk_bin4", bin_out, 4);
    chk("lk_locked4", locked, 1);
    chk("lk_errs", err_count, 0);

    // Skip 5 -> 7 while locked, then relock on 8..11
    send(pick(8'h07, 8'h05)); chk("sk_ep5", err_pulse, 0);
    send(pick(8'h04, 8'h07));
    chk("sk_ep", err_pulse, 1);
    chk("sk_bin", bin_out, 7);
    chk("sk_errs", err_count, 1);
    chk("sk_unlock", locked, 0);
    chk("sk_sat1", err_count2, 1);
    for (int b = 8; b <= 11; b++) begin
      send(enc(b));
      chk("sk_ep_after", err_pulse, 0);
      chk("sk_relock", locked, (b == 11) ? 1 : 0);
    end

    // Jump near the top, relock, then wrap
    send(enc(8'hF9));
    chk("wp_ep", err_pulse, 1);
    chk("wp_errs", err_count, 2);
    chk("wp_sat2", err_count2, 2);
    for (int b = 8'hFA; b <= 8'hFD; b++) send(enc(b));
    chk("wp_locked", locked, 1);
    send(pick(8'h81, 8'hFE)); chk("wp_binFE", bin_out, 8'hFE);
    send(pick(8'h80, 8'hFF)); chk("wp_binFF", bin_out, 8'hFF);
    chk("wp_epFF", err_pulse, 0);
    send(pick(8'h00, 8'h00)); chk("wp_bin00", bin_out, 0);
    chk("wp_ep00", err_pulse, 0);
    chk("wp_lk00", locked, 1);

    // Gaps while locked
    send(enc(1));
    send(enc(2));
    idle(3);
    send(enc(3));
    chk("gp_bin", bin_out, 3);
    chk("gp_ep", err_pulse, 0);
    chk("gp_locked", locked, 1);

    // Three more errors: small counter saturates at 3
    cur = 3;
    for (int k = 0; k < 3; k++) begin
      cur = cur + 10;
      send(enc(cur));
      chk("st_ep", err_pulse, 1);
      chk("st_errs", err_count, 3 + k);
      chk("st_sat", err_count2, 3);
      for (int j = 0; j < 4; j++) begin
        cur = cur + 1;
        send(enc(cur));
      end
      chk("st_relock", locked, 1);
    end

    // Asynchronous reset while locked
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_bin_out", bin_out, 0);
    chk("ar_bin_valid", bin_valid, 0);
    chk("ar_locked", locked, 0);
    chk("ar_err_pulse", err_pulse, 0);
    chk("ar_err_count", err_count, 0);
    chk("ar_sat", err_count2, 0);
    @(negedge clk);
    reset = 1'b0;

    // Fresh HUNT after reset
    send(pick(8'h18, 8'h10)); chk("bn_10", bin_out, 8'h10);
    send(pick(8'h19, 8'h11)); chk("bn_11", bin_out, 8'h11);
    send(pick(8'h1B, 8'h12)); chk("bn_12", bin_out, 8'h12);
    send(pick(8'h1A, 8'h13)); chk("bn_13", bin_out, 8'h13);
    chk("bn_lk13", locked, 0);
    send(pick(8'h1E, 8'h14)); chk("bn_14", bin_out, 8'h14);
    chk("bn_lk14", locked, 1);

    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_count_checker.md
# gray_count_checker

Sink-side checker for the free-running counter stream. Accepts one count sample per cycle from a Gray or binary counter and decodes it to binary. Verifies that consecutive samples advance by exactly +1, with wrap-around. Reports lock status, single-cycle error pulses and a saturating error tally, and sits on the receive end of any counter bus crossing a clock or board boundary.

## Interface
- WIDTH, 8: count width in bits (≥2)
- LOCK_COUNT, 4: consecutive good increments required to assert lock (≥1)
- ERR_CNT_W, 8: error counter width
- clk  in  1  clock; all sampling on rising edge
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_count carries a sample this cycle
- in_count  in  WIDTH  sampled count (Gray-coded or binary per Configuration)
- bin_out  out  WIDTH  decoded binary value of last accepted sample
- bin_valid  out  1  bin_out updated this cycle (1-cycle pulse per sample)
- locked  out  1  stream tracked with LOCK_COUNT+ good increments
- err_pulse  out  1  one-cycle pulse: sequence break while locked
- err_count  out  ERR_CNT_W  saturating count of err_pulse events

## Operation
- Decode: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i].
- Good increment: decoded sample == (reference + 1) mod 2^WIDTH. Includes wrap 2^WIDTH-1 → 0. A repeated value is a bad sample.
- Every valid sample becomes the new reference, whether good or bad.
- FSM states: HUNT, ACQUIRE, LOCKED; run counter counts 0..LOCK_COUNT.
- HUNT: the first valid sample loads the reference; run=0; the FSM moves to ACQUIRE. No check is made.
- ACQUIRE:
  - Good sample: run++. When run reaches LOCK_COUNT, the FSM moves to LOCKED.
  - Bad sample: run=0. The FSM stays in ACQUIRE, with no err_pulse and no err_count change.
- LOCKED:
  - Good sample: the FSM stays in LOCKED.
  - Bad sample: err_pulse, err_count++ (saturates at all-ones), run=0, and the FSM moves to ACQUIRE.
- in_valid low: no state, run, reference or output change except that bin_valid and err_pulse read 0. Gaps of any length are legal.
- err_count is cleared only by reset.

## Timing
- All outputs are registered. A sample accepted at edge k produces bin_out/bin_valid at edge k, and they are visible during cycle k+1. Latency is 1 cycle.
- err_pulse is asserted in the same cycle as the bin_valid of the offending sample. err_count shows the incremented value in that same cycle.
- locked rises in the same cycle as the bin_valid of the LOCK_COUNT-th good increment. It falls in the same cycle as err_pulse.
- Throughput is one sample per clock, with no backpressure.
- Reset values: bin_out=0, bin_valid=0, locked=0, err_pulse=0, err_count=0; state HUNT, run=0, reference=0.
- Reset asserted mid-operation forces these values immediately. The first valid sample after deassertion is treated as a HUNT sample.

## Configuration
- GRAY_DECODE_EN defined: in_count is Gray code and is decoded as above.
- GRAY_DECODE_EN undefined: the decoder is removed, in_count is plain binary, and bin_out = in_count. Checking, FSM and timing are identical in both builds.

## Test plan
- Lock acquisition (GRAY_DECODE_EN, defaults):
  - Stimulus: reset, then gray 0x00,0x01,0x03,0x02,0x06 on consecutive cycles.
  - Response: bin_out 0,1,2,3,4; locked rises with the bin_out=4 cycle; err_count=0.
- Wrap:
  - Stimulus: while locked, gray 0x81,0x80,0x00 (bin 0xFE,0xFF,0x00).
  - Response: no err_pulse; locked stays 1.
- Skip:
  - Stimulus: locked at bin 5, then gray 0x04 (bin 7), followed by bin 8,9,10,11.
  - Response: err_pulse for one cycle with bin_out=7; err_count=1; locked drops with that pulse and rises again with the bin_out=11 cycle.
- Gaps:
  - Stimulus: in_valid low for 3 cycles between bin 2 and bin 3 while locked.
  - Response: bin_valid 0 for those cycles; no error; locked held.
- Saturation:
  - Stimulus: ERR_CNT_W=2; cause 5 errors while relocking between each.
  - Response: err_count reads 1,2,3,3,3.
- Reset and binary build:
  - Stimulus: async reset pulse while locked.
  - Response: all outputs 0 immediately.
  - Stimulus: build without GRAY_DECODE_EN, then binary 0x10..0x14.
  - Response: bin_out 0x10..0x14; locked rises with 0x14.
